cacheline_burst_adaptor: RTL

//   Converts the cache's single-transfer 256-bit line requests into 4-beat 64-bit bursts.

---
 rtl/cacheline_burst_adaptor_pkg.sv | 27 ++
 rtl/cacheline_burst_adaptor_beat_buffer.sv | 33 +++
 rtl/cacheline_burst_adaptor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and sizes for the cacheline-to-burst adaptor.
// Line and beat geometry, the adaptor state enum and the address alignment helper.
package cache_types;

    localparam int s_line   = 256;
    localparam int s_burst  = 64;
    localparam int s_beats  = s_line / s_burst;
    localparam int s_offset = 5;
    localparam int cnt_w    = $clog2(s_beats);

    typedef logic [s_burst-1:0] burst_t;
    typedef logic [s_line-1:0]  llc_cacheline;
    typedef logic [cnt_w-1:0]   beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    // Memory only sees line-aligned addresses; the offset bits are cleared.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:s_offset], {s_offset{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_beat_buffer.sv
// Beat storage for line fills plus a beat selector for writebacks.
// Fill beats are written by index; writeback beats are picked from the cache's line by index.
module burst_beat_buffer
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  beat_idx_t    wr_idx,
    input  burst_t       wr_data,
    output llc_cacheline line_out,
    input  llc_cacheline rd_line,
    input  beat_idx_t    rd_idx,
    output burst_t       rd_beat
);

    logic [s_beats-1:0][s_burst-1:0] beats;
    logic [s_beats-1:0][s_burst-1:0] rd_view;

    // Beat k lives at line[k*s_burst +: s_burst], which is exactly packed element k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats <= '0;
        end else if (wr_en) begin
            beats[wr_idx] <= wr_data;
        end
    end

    assign line_out = beats;
    assign rd_view  = rd_line;
    assign rd_beat  = rd_view[rd_idx];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns single 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Optional ADAPTOR_PERF_CNT_EN adds rd_count/wr_count completed-burst counters.
module cacheline_burst_adaptor
    import cache_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_address,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [s_line-1:0]  line_wdata,
    output logic [s_line-1:0]  line_rdata,
    output logic               line_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
`ifdef ADAPTOR_PERF_CNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    adaptor_state_t state, state_next;
    beat_idx_t      cnt, cnt_next;
    logic [31:0]    addr_q;
    logic           accept;
    logic           last_beat;
    burst_t         wr_beat;

    assign accept    = (state == IDLE) && (line_read || line_write);
    assign last_beat = (cnt == beat_idx_t'(s_beats - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q <= line_align(line_address);
            end
        end
    end

    // Write wins over read; the counter only moves on a memory ack and wraps into DONE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (line_write) begin
                    state_next = WRITE;
                end else if (line_read) begin
                    state_next = READ;
                end
            end
            READ, WRITE: begin
                if (burst_resp) begin
                    if (last_beat) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + beat_idx_t'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    burst_beat_buffer u_beat_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    ((state == READ) && burst_resp),
        .wr_idx   (cnt),
        .wr_data  (burst_rdata),
        .line_out (line_rdata),
        .rd_line  (line_wdata),
        .rd_idx   (cnt),
        .rd_beat  (wr_beat)
    );

    assign burst_read    = (state == READ);
    assign burst_write   = (state == WRITE);
    assign line_resp     = (state == DONE);
    assign burst_address = addr_q;
    assign burst_wdata   = (state == WRITE) ? wr_beat : '0;

`ifdef ADAPTOR_PERF_CNT_EN
    logic op_is_write;

    // The DONE state is shared, so remember which kind of burst is finishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_is_write <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            if (accept) begin
                op_is_write <= line_write;
            end
            if (state == DONE) begin
                if (op_is_write) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule
